epoch_redirect_ctrl: RTL and testbench

Sequences pipeline redirects for the chromite core. It arbitrates redirect requests from execute (branch mispredict) and writeback (trap), and drops stale ones by epoch tag. For each accepted request it toggles the matching epoch bit (eEpoch/wEpoch), pulses the stage2 update enables and delivers the redirect PC to fetch over a valid/ready handshake. A bounded drain window follows each redirect while the pipeline empties.

---
 rtl/epoch_redirect_pkg.sv | 24 ++
 rtl/sat_counter.sv | 23 ++
 rtl/epoch_redirect_ctrl.sv | 153 +++++++++++++++
 tb/tb_epoch_redirect_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/epoch_redirect_pkg.sv
// rtl/epoch_redirect_pkg.sv - shared types and constants for the epoch redirect controller
package epoch_redirect_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    typedef enum logic {
        SRC_EXE = 1'b0,
        SRC_WB  = 1'b1
    } src_t;

    localparam int DEF_DRAIN_CYCLES = 2;
    localparam int DRAIN_W          = $clog2(DEF_DRAIN_CYCLES + 1);

    // Drain counter width for an arbitrary window; never narrower than one bit
    // so a zero-length window still yields a legal vector.
    function automatic int calc_drain_w(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    // Count increments; holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/epoch_redirect_ctrl.sv
// rtl/epoch_redirect_ctrl.sv - arbitrates exe/trap redirects, toggles epochs, drives fetch redirect
module epoch_redirect_ctrl
    import epoch_redirect_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             exe_redirect_valid,
    input  logic [XLEN-1:0]  exe_redirect_pc,
    input  logic             exe_redirect_epoch,
    input  logic             wb_trap_valid,
    input  logic [XLEN-1:0]  wb_trap_pc,
    input  logic             wb_trap_epoch,
    output logic             fetch_redirect_valid,
    output logic [XLEN-1:0]  fetch_redirect_pc,
    input  logic             fetch_redirect_ready,
    output logic             eepoch,
    output logic             wepoch,
    output logic             en_update_eepoch,
    output logic             en_update_wepoch,
    output logic             flush_busy,
    output logic [CNT_W-1:0] redirect_count
);

    localparam int DW = calc_drain_w(DRAIN_CYCLES);

    state_t          state, state_n;
    src_t            src, src_n;
    logic [XLEN-1:0] pc_q, pc_n;
    logic            valid_q, valid_n;
    logic [DW-1:0]   drain_cnt, drain_n;
    logic            eepoch_q, wepoch_q;
    logic            tog_e, tog_w;
    logic            pulse_e_q, pulse_w_q;
    logic            trap_live, exe_live;

    // A request only counts if it was issued under the epoch currently in force.
    assign trap_live = wb_trap_valid && (wb_trap_epoch == wepoch_q);
    assign exe_live  = exe_redirect_valid && (exe_redirect_epoch == eepoch_q);

    // Next-state logic: trap beats exe, trap may preempt a pending exe redirect.
    always_comb begin
        state_n = state;
        src_n   = src;
        pc_n    = pc_q;
        valid_n = valid_q;
        drain_n = drain_cnt;
        tog_e   = 1'b0;
        tog_w   = 1'b0;
        case (state)
            IDLE: begin
                if (trap_live) begin
                    state_n = REDIRECT;
                    src_n   = SRC_WB;
                    pc_n    = wb_trap_pc;
                    valid_n = 1'b1;
                    tog_w   = 1'b1;
                end else if (exe_live) begin
                    state_n = REDIRECT;
                    src_n   = SRC_EXE;
                    pc_n    = exe_redirect_pc;
                    valid_n = 1'b1;
                    tog_e   = 1'b1;
                end
            end
            REDIRECT: begin
                if (trap_live && (src == SRC_EXE)) begin
                    // Any coincident handshake consumed the old pc; offer the trap next.
                    src_n   = SRC_WB;
                    pc_n    = wb_trap_pc;
                    valid_n = 1'b1;
                    tog_w   = 1'b1;
                end else if (fetch_redirect_ready) begin
                    valid_n = 1'b0;
                    if (DRAIN_CYCLES == 0) begin
                        state_n = IDLE;
                        drain_n = '0;
                    end else begin
                        state_n = DRAIN;
                        drain_n = DW'(DRAIN_CYCLES);
                    end
                end
            end
            DRAIN: begin
                if (trap_live) begin
                    state_n = REDIRECT;
                    src_n   = SRC_WB;
                    pc_n    = wb_trap_pc;
                    valid_n = 1'b1;
                    tog_w   = 1'b1;
                    drain_n = '0;
                end else if (drain_cnt <= DW'(1)) begin
                    state_n = IDLE;
                    drain_n = '0;
                end else begin
                    drain_n = drain_cnt - DW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
                drain_n = '0;
            end
        endcase
    end

    // State, redirect payload, epochs and one-cycle update pulses.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            src       <= SRC_EXE;
            pc_q      <= '0;
            valid_q   <= 1'b0;
            drain_cnt <= '0;
            eepoch_q  <= 1'b0;
            wepoch_q  <= 1'b0;
            pulse_e_q <= 1'b0;
            pulse_w_q <= 1'b0;
        end else begin
            state     <= state_n;
            src       <= src_n;
            pc_q      <= pc_n;
            valid_q   <= valid_n;
            drain_cnt <= drain_n;
            eepoch_q  <= eepoch_q ^ tog_e;
            wepoch_q  <= wepoch_q ^ tog_w;
            pulse_e_q <= tog_e;
            pulse_w_q <= tog_w;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_count (
        .clk   (CLK),
        .rst_n (RST_N),
        .inc   (tog_e | tog_w),
        .clear (1'b0),
        .count (redirect_count)
    );

    assign fetch_redirect_valid = valid_q;
    assign fetch_redirect_pc    = pc_q;
    assign eepoch               = eepoch_q;
    assign wepoch               = wepoch_q;
    assign en_update_eepoch     = pulse_e_q;
    assign en_update_wepoch     = pulse_w_q;
    assign flush_busy           = (state != IDLE);

endmodule

// File: tb/tb_epoch_redirect_ctrl.sv
// tb/tb_epoch_redirect_ctrl.sv - scoreboard bench for epoch_redirect_ctrl
module tb_epoch_redirect_ctrl;

    logic        CLK;
    logic        RST_N;
    logic        exe_redirect_valid;
    logic [63:0] exe_redirect_pc;
    logic        exe_redirect_epoch;
    logic        wb_trap_valid;
    logic [63:0] wb_trap_pc;
    logic        wb_trap_epoch;
    logic        fetch_redirect_valid;
    logic [63:0] fetch_redirect_pc;
    logic        fetch_redirect_ready;
    logic        eepoch;
    logic        wepoch;
    logic        en_update_eepoch;
    logic        en_update_wepoch;
    logic        flush_busy;
    logic [15:0] redirect_count;

    int passed = 0;
    int total  = 0;
    logic [63:0] exp_q[$];

    epoch_redirect_ctrl #(
        .XLEN(64),
        .DRAIN_CYCLES(2),
        .CNT_W(16)
    ) dut (
        .CLK                  (CLK),
        .RST_N                (RST_N),
        .exe_redirect_valid   (exe_redirect_valid),
        .exe_redirect_pc      (exe_redirect_pc),
        .exe_redirect_epoch   (exe_redirect_epoch),
        .wb_trap_valid        (wb_trap_valid),
        .wb_trap_pc           (wb_trap_pc),
        .wb_trap_epoch        (wb_trap_epoch),
        .fetch_redirect_valid (fetch_redirect_valid),
        .fetch_redirect_pc    (fetch_redirect_pc),
        .fetch_redirect_ready (fetch_redirect_ready),
        .eepoch               (eepoch),
        .wepoch               (wepoch),
        .en_update_eepoch     (en_update_eepoch),
        .en_update_wepoch     (en_update_wepoch),
        .flush_busy           (flush_busy),
        .redirect_count       (redirect_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic exe_req(input logic [63:0] pc, input logic tag);
        exe_redirect_valid = 1'b1;
        exe_redirect_pc    = pc;
        exe_redirect_epoch = tag;
    endtask

    task automatic trap_req(input logic [63:0] pc, input logic tag);
        wb_trap_valid = 1'b1;
        wb_trap_pc    = pc;
        wb_trap_epoch = tag;
    endtask

    task automatic clr_req();
        exe_redirect_valid = 1'b0;
        wb_trap_valid      = 1'b0;
    endtask

    // Monitor: every completed fetch handshake must match the next expected pc.
    always @(negedge CLK) begin
        if (RST_N && fetch_redirect_valid && fetch_redirect_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_handshake", fetch_redirect_pc, 64'hDEAD_DEAD_DEAD_DEAD);
            end else begin
                chk("handshake_pc", fetch_redirect_pc, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0;
        fetch_redirect_ready = 1'b0;
        exe_redirect_pc = '0;
        exe_redirect_epoch = 1'b0;
        wb_trap_pc = '0;
        wb_trap_epoch = 1'b0;
        clr_req();
        tick();
        tick();
        chk("rst_valid", fetch_redirect_valid, 0);
        chk("rst_pc", fetch_redirect_pc, 0);
        chk("rst_epochs", {eepoch, wepoch, en_update_eepoch, en_update_wepoch}, 0);
        chk("rst_busy", flush_busy, 0);
        chk("rst_count", redirect_count, 0);
        RST_N = 1'b1;
        tick();

        // Single exe redirect with ready high
        fetch_redirect_ready = 1'b1;
        exe_req(64'h8000_1000, 1'b0);
        exp_q.push_back(64'h8000_1000);
        tick();
        clr_req();
        chk("t1_valid", fetch_redirect_valid, 1);
        chk("t1_pc", fetch_redirect_pc, 64'h8000_1000);
        chk("t1_eepoch", eepoch, 1);
        chk("t1_pulse_e", en_update_eepoch, 1);
        chk("t1_pulse_w", en_update_wepoch, 0);
        chk("t1_count", redirect_count, 1);
        tick();
        chk("t1_pulse_end", en_update_eepoch, 0);
        chk("t1_drain_valid", fetch_redirect_valid, 0);
        chk("t1_drain_busy", flush_busy, 1);
        tick();
        chk("t1_drain2_busy", flush_busy, 1);
        tick();
        chk("t1_idle", flush_busy, 0);

        // Stale exe tag dropped
        exe_req(64'h1234, 1'b0);
        tick();
        clr_req();
        chk("stale_busy", flush_busy, 0);
        chk("stale_pulse", en_update_eepoch, 0);
        chk("stale_eepoch", eepoch, 1);
        chk("stale_count", redirect_count, 1);

        // Simultaneous live exe and trap: trap wins
        exe_req(64'h100, 1'b1);
        trap_req(64'h200, 1'b0);
        exp_q.push_back(64'h200);
        tick();
        clr_req();
        chk("sim_pc", fetch_redirect_pc, 64'h200);
        chk("sim_wepoch", wepoch, 1);
        chk("sim_eepoch", eepoch, 1);
        chk("sim_pulses", {en_update_eepoch, en_update_wepoch}, 2'b01);
        chk("sim_count", redirect_count, 2);
        tick();
        tick();
        tick();
        chk("sim_idle", flush_busy, 0);

        // Preemption of a held exe redirect by a trap
        fetch_redirect_ready = 1'b0;
        exe_req(64'h100, 1'b1);
        tick();
        clr_req();
        chk("pre_exe_pc", fetch_redirect_pc, 64'h100);
        chk("pre_eepoch", eepoch, 0);
        chk("pre_count1", redirect_count, 3);
        tick();
        chk("pre_hold_pc", fetch_redirect_pc, 64'h100);
        trap_req(64'h300, 1'b1);
        exe_req(64'h999, 1'b0);
        exp_q.push_back(64'h300);
        tick();
        clr_req();
        chk("pre_trap_pc", fetch_redirect_pc, 64'h300);
        chk("pre_valid", fetch_redirect_valid, 1);
        chk("pre_wepoch", wepoch, 0);
        chk("pre_eepoch_kept", eepoch, 0);
        chk("pre_pulse_w", en_update_wepoch, 1);
        chk("pre_count2", redirect_count, 4);
        fetch_redirect_ready = 1'b1;
        tick();
        chk("pre_drain_valid", fetch_redirect_valid, 0);
        tick();
        tick();
        chk("pre_idle", flush_busy, 0);

        // Backpressure: five cycles of ready low
        fetch_redirect_ready = 1'b0;
        exe_req(64'h4000, 1'b0);
        exp_q.push_back(64'h4000);
        tick();
        clr_req();
        for (int i = 0; i < 6; i++) begin
            chk("bp_valid", fetch_redirect_valid, 1);
            chk("bp_pc", fetch_redirect_pc, 64'h4000);
            chk("bp_busy", flush_busy, 1);
            if (i == 5) fetch_redirect_ready = 1'b1;
            tick();
        end
        chk("bp_drain_valid", fetch_redirect_valid, 0);
        chk("bp_drain_busy", flush_busy, 1);
        chk("bp_count", redirect_count, 5);
        tick();
        tick();
        chk("bp_idle", flush_busy, 0);

        // Reset asserted mid-DRAIN clears outputs without a clock edge
        exe_req(64'h5000, 1'b1);
        exp_q.push_back(64'h5000);
        tick();
        clr_req();
        tick();
        chk("rm_in_drain", flush_busy, 1);
        @(negedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        chk("rm_valid", fetch_redirect_valid, 0);
        chk("rm_pc", fetch_redirect_pc, 0);
        chk("rm_epochs", {eepoch, wepoch, en_update_eepoch, en_update_wepoch}, 0);
        chk("rm_busy", flush_busy, 0);
        chk("rm_count", redirect_count, 0);
        tick();
        RST_N = 1'b1;
        tick();
        exe_req(64'h6000, 1'b0);
        exp_q.push_back(64'h6000);
        tick();
        clr_req();
        chk("post_pc", fetch_redirect_pc, 64'h6000);
        chk("post_eepoch", eepoch, 1);
        chk("post_count", redirect_count, 1);
        tick();

        // Trap arriving during DRAIN redirects again
        chk("dt_in_drain", flush_busy, 1);
        trap_req(64'h7000, 1'b0);
        exp_q.push_back(64'h7000);
        tick();
        clr_req();
        chk("dt_valid", fetch_redirect_valid, 1);
        chk("dt_pc", fetch_redirect_pc, 64'h7000);
        chk("dt_wepoch", wepoch, 1);
        chk("dt_count", redirect_count, 2);
        tick();
        tick();
        tick();
        chk("dt_idle", flush_busy, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
